// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares the single SRAM port between the CPU (port 0)
// and the program loader / debug DMA (port 1). Every access holds Mem_OE or
// Mem_WE for WAIT_CYCLES cycles, then pulses the requester's done for one
// cycle with registered read data on rdata.
//
// Build option: define ARB_CPU_PRIORITY_EN to make port 0 win every tie
// (fixed priority). Left undefined, ties alternate round-robin, and port 0
// wins the first tie after reset.

module sram_access_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_WDATA,
    input  logic [DATA_W-1:0] SRAM_RDATA
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               grant_any;
    logic               grant_port;
    logic               port_l;
    logic               we_l;
    logic [CNT_W-1:0]   wait_cnt;

`ifndef ARB_CPU_PRIORITY_EN
    logic               rr_last;
`endif

    // Pick the winner among the current requests (only acted on in IDLE)
    always_comb begin
        grant_any  = req0 | req1;
        grant_port = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
        grant_port = ~req0;
`else
        if (req0 && req1) begin
            grant_port = ~rr_last;
        end else begin
            grant_port = ~req0;
        end
`endif
    end

    // State register; reset abandons any access in flight without a done pulse
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> ACCESS for WAIT_CYCLES cycles -> DONE -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt == '0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Access datapath: latch the winner's request at grant, count wait cycles, capture read data
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            port_l     <= 1'b0;
            we_l       <= 1'b0;
            wait_cnt   <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
            rdata      <= '0;
`ifndef ARB_CPU_PRIORITY_EN
            rr_last    <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        port_l     <= grant_port;
                        we_l       <= grant_port ? we1 : we0;
                        SRAM_ADDR  <= grant_port ? addr1 : addr0;
                        SRAM_WDATA <= grant_port ? wdata1 : wdata0;
                        wait_cnt   <= CNT_W'(WAIT_CYCLES - 1);
`ifndef ARB_CPU_PRIORITY_EN
                        rr_last    <= grant_port;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        if (!we_l) begin
                            rdata <= SRAM_RDATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state so OE and WE are mutually exclusive and drop as soon as ACCESS ends
    always_comb begin
        busy   = (state != ST_IDLE);
        Mem_OE = (state == ST_ACCESS) && !we_l;
        Mem_WE = (state == ST_ACCESS) && we_l;
        done0  = (state == ST_DONE) && !port_l;
        done1  = (state == ST_DONE) && port_l;
    end

endmodule
